// File: rtl/uart_parse_pkg.sv
// Byte constants, parser state and byte-class types shared by the UART
// integer-list parser and its digit accumulator.
package uart_parse_pkg;

  localparam logic [7:0] CH_0     = 8'h30;
  localparam logic [7:0] CH_9     = 8'h39;
  localparam logic [7:0] CH_SPACE = 8'h20;
  localparam logic [7:0] CH_TAB   = 8'h09;
  localparam logic [7:0] CH_COMMA = 8'h2C;
  localparam logic [7:0] CH_MINUS = 8'h2D;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_LF    = 8'h0A;

  typedef enum logic [1:0] {S_SEP, S_SIGN, S_NUM, S_ERR} parse_state_e;

  typedef enum logic [2:0] {DIGIT, SEP, MINUS, CR, LF, OTHER} byte_class_e;

  function automatic byte_class_e classify_byte(input logic [7:0] b);
    byte_class_e cls;
    if (b >= CH_0 && b <= CH_9)                              cls = DIGIT;
    else if (b == CH_SPACE || b == CH_TAB || b == CH_COMMA)  cls = SEP;
    else if (b == CH_MINUS)                                  cls = MINUS;
    else if (b == CH_CR)                                     cls = CR;
    else if (b == CH_LF)                                     cls = LF;
    else                                                     cls = OTHER;
    return cls;
  endfunction

endpackage

// File: rtl/dec_digit_accumulator.sv
// Combinational acc*10 + digit step with range check. The accumulator holds a
// magnitude, so negative numbers may reach 2^(VW-1) while positives stop one short.
module dec_digit_accumulator
  import uart_parse_pkg::*;
#(
  parameter int VALUE_WIDTH = 8,
  parameter bit SIGNED_MODE = 1'b0
) (
  input  logic [VALUE_WIDTH-1:0] acc_i,
  input  logic [3:0]             digit_i,
  input  logic                   neg_i,
  output logic [VALUE_WIDTH-1:0] sum_o,
  output logic                   ovf_o
);

  localparam int WW = VALUE_WIDTH + 4;
  localparam logic [WW-1:0] LIM_UNS = {4'b0, {VALUE_WIDTH{1'b1}}};
  localparam logic [WW-1:0] LIM_POS = {5'b0, {(VALUE_WIDTH-1){1'b1}}};
  localparam logic [WW-1:0] LIM_NEG = LIM_POS + WW'(1);

  logic [WW-1:0] wide;
  logic [WW-1:0] limit;

  always_comb begin
    wide = WW'(acc_i) * WW'(10) + WW'(digit_i);
    if (!SIGNED_MODE) limit = LIM_UNS;
    else if (neg_i)   limit = LIM_NEG;
    else              limit = LIM_POS;
    ovf_o = (wide > limit);
    sum_o = wide[VALUE_WIDTH-1:0];
  end

endmodule

// File: rtl/uart_int_list_parser.sv
// Streaming parser turning UART RX bytes into one line of up to MAX_COUNT
// decimal integers, with done/error/busy status for the operand-selection FSMs.
module uart_int_list_parser
  import uart_parse_pkg::*;
#(
  parameter int MAX_COUNT   = 4,
  parameter int VALUE_WIDTH = 8,
  parameter bit ALLOW_SIGN  = 1'b0,
  localparam int CW = $clog2(MAX_COUNT + 1)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             clear,
  input  logic [7:0]                       rx_data,
  input  logic                             rx_valid,
  output logic [MAX_COUNT*VALUE_WIDTH-1:0] values,
  output logic [CW-1:0]                    count,
  output logic                             done,
  output logic                             error,
  output logic                             busy
);

  parse_state_e                     state_q, state_d;
  logic [VALUE_WIDTH-1:0]           acc_q, acc_d;
  logic                             neg_q, neg_d;
  logic [MAX_COUNT*VALUE_WIDTH-1:0] values_q, values_d;
  logic [CW-1:0]                    count_q, count_d;
  logic                             done_q, done_d;
  logic                             error_q, error_d;
  logic                             busy_q, busy_d;

  byte_class_e            cls;
  logic [3:0]             digit;
  logic [VALUE_WIDTH-1:0] acc_next;
  logic                   acc_ovf;
  logic [VALUE_WIDTH-1:0] commit_val;
  logic                   do_commit, do_finish, go_err;

  assign cls        = classify_byte(rx_data);
  assign digit      = rx_data[3:0];
  assign commit_val = neg_q ? (VALUE_WIDTH'(0) - acc_q) : acc_q;

  dec_digit_accumulator #(
    .VALUE_WIDTH (VALUE_WIDTH),
    .SIGNED_MODE (ALLOW_SIGN)
  ) u_acc (
    .acc_i   (acc_q),
    .digit_i (digit),
    .neg_i   (neg_q),
    .sum_o   (acc_next),
    .ovf_o   (acc_ovf)
  );

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    neg_d     = neg_q;
    values_d  = values_q;
    count_d   = count_q;
    error_d   = error_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    do_commit = 1'b0;
    do_finish = 1'b0;
    go_err    = 1'b0;

    if (rx_valid) begin
      // Any byte arriving while idle opens a new line and wipes the previous result.
      if (!busy_q) begin
        values_d = '0;
        count_d  = '0;
        error_d  = 1'b0;
        busy_d   = 1'b1;
      end

      if (cls != CR) begin
        case (state_q)
          S_SEP: begin
            case (cls)
              DIGIT: begin
                acc_d   = VALUE_WIDTH'(digit);
                neg_d   = 1'b0;
                state_d = S_NUM;
              end
              MINUS: begin
                if (ALLOW_SIGN) begin
                  neg_d   = 1'b1;
                  state_d = S_SIGN;
                end else begin
                  go_err = 1'b1;
                end
              end
              SEP:     state_d = S_SEP;
              LF:      do_finish = 1'b1;
              default: go_err = 1'b1;
            endcase
          end
          S_SIGN: begin
            if (cls == DIGIT) begin
              acc_d   = VALUE_WIDTH'(digit);
              state_d = S_NUM;
            end else if (cls == LF) begin
              error_d   = 1'b1;
              do_finish = 1'b1;
            end else begin
              go_err = 1'b1;
            end
          end
          S_NUM: begin
            case (cls)
              DIGIT: begin
                if (acc_ovf) go_err = 1'b1;
                else         acc_d  = acc_next;
              end
              SEP: begin
                do_commit = 1'b1;
                state_d   = S_SEP;
              end
              LF: begin
                do_commit = 1'b1;
                do_finish = 1'b1;
              end
              default: go_err = 1'b1;
            endcase
          end
          S_ERR: begin
            if (cls == LF) do_finish = 1'b1;
          end
          default: go_err = 1'b1;
        endcase
      end
    end

    if (do_commit) begin
      if (count_q == CW'(MAX_COUNT)) begin
        error_d = 1'b1;
        if (!do_finish) state_d = S_ERR;
      end else begin
        for (int k = 0; k < MAX_COUNT; k++) begin
          if (count_q == CW'(k)) values_d[k*VALUE_WIDTH +: VALUE_WIDTH] = commit_val;
        end
        count_d = count_q + CW'(1);
      end
    end

    if (go_err) begin
      error_d = 1'b1;
      state_d = S_ERR;
    end

    if (do_finish) begin
      state_d = S_SEP;
      busy_d  = 1'b0;
      done_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_SEP;
      acc_q    <= '0;
      neg_q    <= 1'b0;
      values_q <= '0;
      count_q  <= '0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else if (clear) begin
      state_q  <= S_SEP;
      acc_q    <= '0;
      neg_q    <= 1'b0;
      values_q <= '0;
      count_q  <= '0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      neg_q    <= neg_d;
      values_q <= values_d;
      count_q  <= count_d;
      done_q   <= done_d;
      error_q  <= error_d;
      busy_q   <= busy_d;
    end
  end

  assign values = values_q;
  assign count  = count_q;
  assign done   = done_q;
  assign error  = error_q;
  assign busy   = busy_q;

endmodule

// File: doc/uart_int_list_parser.md
Name: uart_int_list_parser

Overview:
- Streaming parser that turns UART bytes into a line of up to MAX_COUNT decimal integers, e.g. dimension entry "2 2\n" or ID entry "1\n".
- Generalised successor of the fixed-format dimension/ID input path in compute_subsystem: parametrised token count and value width, optional signed mode, explicit overflow/format error reporting.
- Sits between the UART RX byte stream and the operand-selection FSMs.

Parameters:
- MAX_COUNT, 4, maximum integers per line.
- VALUE_WIDTH, 8, bits per parsed value.
- ALLOW_SIGN, 0, 1 accepts a leading '-' and emits two's-complement values.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- clear  input  1  synchronous flush of all state and outputs; same effect as reset.
- rx_data  input  8  received byte.
- rx_valid  input  1  one-cycle strobe; rx_data is valid this cycle.
- values  output  MAX_COUNT*VALUE_WIDTH  parsed values; token k in bits [k*VALUE_WIDTH +: VALUE_WIDTH].
- count  output  $clog2(MAX_COUNT+1)  number of values committed on the current line.
- done  output  1  one-cycle pulse when a line completes.
- error  output  1  line status flag.
- busy  output  1  high while a line is in progress.

Behaviour:
- Reset/clear: all outputs 0; state S_SEP.
- Byte acceptance: one byte per rx_valid; back-to-back valid on consecutive cycles must be supported. Bytes are classified using package constants.
- Line start: the first byte of a new line (any byte received while busy=0) clears values, count and error in the same cycle it is processed, then sets busy=1.
- S_SEP (between tokens):
  - digit -> acc=digit, neg=0, go S_NUM.
  - '-' with ALLOW_SIGN=1 -> neg=1, go S_SIGN.
  - space, tab, ',' -> stay.
  - '\r' -> ignored in every state.
  - '\n' -> finish line.
  - anything else -> S_ERR.
- S_SIGN:
  - digit -> acc=digit, go S_NUM.
  - any other byte, including '\n' -> error.
- S_NUM:
  - digit -> acc = acc*10 + d, computed at VALUE_WIDTH+4 bits.
  - overflow (go S_ERR) if:
    - unsigned result > 2^VW-1;
    - signed positive result > 2^(VW-1)-1;
    - signed negative magnitude > 2^(VW-1).
  - separator -> commit token; '\n' -> commit token, then finish line.
  - any other byte -> S_ERR.
- Commit: values[count] <= neg ? -acc : acc; count++. If count==MAX_COUNT before the commit, nothing is stored and the line goes to error.
- S_ERR: sets error=1 and discards bytes until '\n', then finishes the line.
- Finish line: the cycle after the '\n' byte, done=1 for exactly one cycle and busy=0. values, count and error hold until the next line starts or clear.
- An empty line ("\n") gives done with count=0 and error=0.
- On error, values committed before the fault remain visible; consumers must check error.
- clear and rx_valid in the same cycle: clear wins and the byte is dropped.
- Reset asserted mid-line: all state is discarded; the next byte starts a fresh line.

Decomposition:
- Package uart_parse_pkg holds:
  - ASCII constants: '0', '9', ' ', '\t', ',', '-', '\r', '\n';
  - parser state enum {S_SEP, S_SIGN, S_NUM, S_ERR};
  - byte-class enum {DIGIT, SEP, MINUS, CR, LF, OTHER}.
- One sub-module, dec_digit_accumulator: combinational acc*10+d with overflow flag, parametrised by VALUE_WIDTH and signed mode.

Test Plan:
1. "2 2\n", rx_valid every 6 cycles -> count=2, values[0]=2, values[1]=2, error=0, single done pulse one cycle after '\n'.
2. VALUE_WIDTH=8: "255,7\r\n" -> values 255 and 7, count=2, error=0. Then "256\n" -> error=1, count=0.
3. MAX_COUNT=4: "1 2 3 4 5\n" -> error=1, count=4, values 1..4.
4. ALLOW_SIGN=1:
   - "-128 127\n" -> 0x80, 0x7F, error=0;
   - "-129\n" -> error=1;
   - "-\n" -> error=1;
   - "5-\n" -> error=1.
5. "1x9\n" -> error=1. Then "3\n" -> error=0, count=1, value 3. "\n" alone -> done, count=0.
6. Bytes on consecutive cycles: "12 34\n" -> values 12 and 34. "12" then rst_n pulse low, then "5\n" -> count=1, value 5. clear asserted mid-line -> outputs 0, done never pulses.
